// File: rtl/uart_mem_master_if.sv
// Byte-stream and picorv32-native memory bus bundle for uart_mem_master.
// master = the bridge itself, slave = the UART/memory side.
interface uart_mem_master_if;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_tdata, rx_tvalid, tx_tready, mem_ready, mem_rdata,
    output rx_tready, tx_tdata, tx_tvalid, mem_valid, mem_instr,
    output mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_tdata, rx_tvalid, tx_tready, mem_ready, mem_rdata,
    input  rx_tready, tx_tdata, tx_tvalid, mem_valid, mem_instr,
    input  mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/uart_mem_master.sv
// UART-driven memory bus initiator: decodes 'R'/'W' word commands from the rx
// byte stream, runs one picorv32-native bus transaction and replies on tx.
module uart_mem_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit WRITE_ACK      = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  uart_mem_master_if.master  bus,
  output logic               busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_reg;
  logic [1:0]  cnt_reg;
  logic        write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] resp_reg;
  logic [2:0]  resp_len_reg;
  logic [15:0] tmo_reg;
  logic        rx_tready_reg;
  logic        tx_tvalid_reg;
  logic        mem_valid_reg;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = bus.rx_tvalid && rx_tready_reg;
  assign tx_fire = tx_tvalid_reg && bus.tx_tready;

  // rx_tready is registered so it reads 0 while in reset and rises one edge later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 2'd0;
      write_reg     <= 1'b0;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      resp_reg      <= 32'h0;
      resp_len_reg  <= 3'd0;
      tmo_reg       <= 16'h0;
      rx_tready_reg <= 1'b0;
      tx_tvalid_reg <= 1'b0;
      mem_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          rx_tready_reg <= 1'b1;
          if (rx_fire) begin
            if (bus.rx_tdata == CMD_WRITE || bus.rx_tdata == CMD_READ) begin
              write_reg <= (bus.rx_tdata == CMD_WRITE);
              cnt_reg   <= 2'd0;
              state_reg <= S_ADDR;
            end else begin
              resp_reg      <= {24'h0, RSP_ERR};
              resp_len_reg  <= 3'd1;
              tx_tvalid_reg <= 1'b1;
              rx_tready_reg <= 1'b0;
              state_reg     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            // Low two address bits are dropped on capture: the bus is word-only.
            addr_reg[8*cnt_reg +: 8] <= (cnt_reg == 2'd0) ? {bus.rx_tdata[7:2], 2'b00}
                                                           : bus.rx_tdata;
            cnt_reg <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
              if (write_reg) begin
                state_reg <= S_DATA;
              end else begin
                mem_valid_reg <= 1'b1;
                rx_tready_reg <= 1'b0;
                tmo_reg       <= 16'h0;
                state_reg     <= S_MEM;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            wdata_reg[8*cnt_reg +: 8] <= bus.rx_tdata;
            cnt_reg <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
              mem_valid_reg <= 1'b1;
              rx_tready_reg <= 1'b0;
              tmo_reg       <= 16'h0;
              state_reg     <= S_MEM;
            end
          end
        end

        S_MEM: begin
          // A ready on the final timeout edge still completes normally.
          if (bus.mem_ready) begin
            mem_valid_reg <= 1'b0;
            tmo_reg       <= 16'h0;
            if (!write_reg) begin
              resp_reg      <= bus.mem_rdata;
              resp_len_reg  <= 3'd4;
              tx_tvalid_reg <= 1'b1;
              state_reg     <= S_RESP;
            end else if (WRITE_ACK) begin
              resp_reg      <= {24'h0, RSP_ACK};
              resp_len_reg  <= 3'd1;
              tx_tvalid_reg <= 1'b1;
              state_reg     <= S_RESP;
            end else begin
              rx_tready_reg <= 1'b1;
              state_reg     <= S_IDLE;
            end
          end else if (TMO_EN && tmo_reg == TMO_LAST) begin
            mem_valid_reg <= 1'b0;
            tmo_reg       <= 16'h0;
            resp_reg      <= {24'h0, RSP_TMO};
            resp_len_reg  <= 3'd1;
            tx_tvalid_reg <= 1'b1;
            state_reg     <= S_RESP;
          end else begin
            tmo_reg <= tmo_reg + 16'h1;
          end
        end

        S_RESP: begin
          // Reply bytes shift out of the low byte, so tx_tdata holds until accepted.
          if (tx_fire) begin
            resp_reg     <= resp_reg >> 8;
            resp_len_reg <= resp_len_reg - 3'd1;
            if (resp_len_reg == 3'd1) begin
              tx_tvalid_reg <= 1'b0;
              rx_tready_reg <= 1'b1;
              state_reg     <= S_IDLE;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_tready = rx_tready_reg;
  assign bus.tx_tdata  = resp_reg[7:0];
  assign bus.tx_tvalid = tx_tvalid_reg;
  assign bus.mem_valid = mem_valid_reg;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_wstrb = (mem_valid_reg && write_reg) ? 4'hF : 4'h0;
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_mem_master.sv
// Bench for uart_mem_master: two instances (8-cycle timeout with write ack,
// and no timeout with silent writes) share one stimulus path selected by sel.
module tb_uart_mem_master;

  localparam int A_TIMEOUT = 8;
  localparam logic [7:0] CW = 8'h57;
  localparam logic [7:0] CR = 8'h52;

  typedef struct {
    bit          sel;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;      // mem_valid cycle in which ready is given, 0 = never
    int          exp_n;
    logic [7:0]  exp_tx[4];
    bit          exp_mem;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    int          exp_vlen;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  rx_tdata = 8'h0;
  logic        rx_tvalid = 1'b0;
  logic        tx_tready = 1'b1;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy_a, busy_b;

  int          rsp_delay = 1;
  logic [31:0] rsp_data = 32'h0;
  bit          stall_en = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  uart_mem_master_if ifa ();
  uart_mem_master_if ifb ();

  uart_mem_master #(.TIMEOUT_CYCLES(A_TIMEOUT), .WRITE_ACK(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa), .busy(busy_a)
  );
  uart_mem_master #(.TIMEOUT_CYCLES(0), .WRITE_ACK(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb), .busy(busy_b)
  );

  assign ifa.rx_tdata  = rx_tdata;
  assign ifb.rx_tdata  = rx_tdata;
  assign ifa.rx_tvalid = rx_tvalid & ~sel;
  assign ifb.rx_tvalid = rx_tvalid & sel;
  assign ifa.tx_tready = tx_tready & ~sel;
  assign ifb.tx_tready = tx_tready & sel;
  assign ifa.mem_ready = mem_ready & ~sel;
  assign ifb.mem_ready = mem_ready & sel;
  assign ifa.mem_rdata = mem_rdata;
  assign ifb.mem_rdata = mem_rdata;

  logic        o_rx_tready, o_tx_tvalid, o_mem_valid, o_mem_instr, o_busy;
  logic [7:0]  o_tx_tdata;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;

  assign o_rx_tready = sel ? ifb.rx_tready : ifa.rx_tready;
  assign o_tx_tvalid = sel ? ifb.tx_tvalid : ifa.tx_tvalid;
  assign o_tx_tdata  = sel ? ifb.tx_tdata  : ifa.tx_tdata;
  assign o_mem_valid = sel ? ifb.mem_valid : ifa.mem_valid;
  assign o_mem_instr = sel ? ifb.mem_instr : ifa.mem_instr;
  assign o_mem_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
  assign o_mem_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;
  assign o_mem_wstrb = sel ? ifb.mem_wstrb : ifa.mem_wstrb;
  assign o_busy      = sel ? busy_b : busy_a;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Responder: ready in the rsp_delay-th cycle of each mem_valid episode.
  int cyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = rsp_data;
      if (o_mem_valid) begin
        cyc++;
        mem_ready = (rsp_delay != 0) && (cyc == rsp_delay);
      end else begin
        cyc = 0;
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) tx_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: logs accepted tx bytes and each mem_valid episode.
  logic [7:0]  tx_log[$];
  logic [31:0] m_addr[$];
  logic [31:0] m_wdata[$];
  logic [3:0]  m_wstrb[$];
  int          m_vlen[$];
  int          vcnt = 0;
  bit          unstable = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;

  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_tvalid && tx_tready) tx_log.push_back(o_tx_tdata);
      if (o_mem_valid) begin
        if (vcnt == 0) begin
          h_addr = o_mem_addr; h_wdata = o_mem_wdata; h_wstrb = o_mem_wstrb;
          unstable = 1'b0;
          m_addr.push_back(o_mem_addr);
          m_wdata.push_back(o_mem_wdata);
          m_wstrb.push_back(o_mem_wstrb);
        end else if (o_mem_addr !== h_addr || o_mem_wdata !== h_wdata || o_mem_wstrb !== h_wstrb) begin
          unstable = 1'b1;
        end
        if (o_mem_instr !== 1'b0) unstable = 1'b1;
        vcnt++;
      end else if (vcnt != 0) begin
        m_vlen.push_back(vcnt);
        check("mem_hold_stable", 32'(unstable), 32'd0);
        vcnt = 0;
      end
    end
  end

  task automatic clear_logs();
    tx_log.delete(); m_addr.delete(); m_wdata.delete(); m_wstrb.delete(); m_vlen.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    if (stall_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_tdata = b;
    rx_tvalid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_rx_tready) break;
    end
    if (k == 200) fail_bound("rx_accept");
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!o_busy && !o_tx_tvalid && !o_mem_valid) break;
    end
    if (k == 600) fail_bound("wait_idle");
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(v.cmd);
    if (v.cmd == CW || v.cmd == CR) begin
      for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
      if (v.cmd == CW) for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
    end
  endtask

  // Reference: expected reply and bus transaction derived from the command rules.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    bit   is_w, is_r, tmo;
    e = v;
    is_w = (v.cmd == CW);
    is_r = (v.cmd == CR);
    e.exp_n = 0;
    e.exp_tx = '{default: 8'h00};
    e.exp_mem = 1'b0;
    e.exp_addr = 32'h0;
    e.exp_wstrb = 4'h0;
    e.exp_vlen = 0;
    if (!is_w && !is_r) begin
      e.exp_n = 1;
      e.exp_tx[0] = 8'h3F;
      return e;
    end
    e.exp_mem = 1'b1;
    e.exp_addr = v.addr & 32'hFFFF_FFFC;
    e.exp_wstrb = is_w ? 4'hF : 4'h0;
    tmo = !v.sel && (v.delay == 0 || v.delay > A_TIMEOUT);
    e.exp_vlen = tmo ? A_TIMEOUT : v.delay;
    if (tmo) begin
      e.exp_n = 1;
      e.exp_tx[0] = 8'h54;
    end else if (is_r) begin
      e.exp_n = 4;
      for (int i = 0; i < 4; i++) e.exp_tx[i] = v.rdata[8*i +: 8];
    end else if (!v.sel) begin
      e.exp_n = 1;
      e.exp_tx[0] = 8'h4B;
    end
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    clear_logs();
    sel = v.sel;
    rsp_delay = v.delay;
    rsp_data = v.rdata;
    @(posedge clk);
    #1;
    send_frame(v);
    wait_idle();
    check($sformatf("v%0d tx_count", idx), 32'(tx_log.size()), 32'(v.exp_n));
    for (int i = 0; i < v.exp_n && i < tx_log.size(); i++)
      check($sformatf("v%0d tx_byte%0d", idx, i), 32'(tx_log[i]), 32'(v.exp_tx[i]));
    check($sformatf("v%0d mem_count", idx), 32'(m_addr.size()), 32'(v.exp_mem));
    if (v.exp_mem && m_addr.size() > 0 && m_vlen.size() > 0) begin
      check($sformatf("v%0d mem_addr", idx), m_addr[0], v.exp_addr);
      check($sformatf("v%0d mem_wstrb", idx), 32'(m_wstrb[0]), 32'(v.exp_wstrb));
      if (v.cmd == CW) check($sformatf("v%0d mem_wdata", idx), m_wdata[0], v.wdata);
      check($sformatf("v%0d valid_cycles", idx), 32'(m_vlen[0]), 32'(v.exp_vlen));
    end
    check($sformatf("v%0d busy_after", idx), 32'(o_busy), 32'd0);
    $display("frame %0d: dut=%0d cmd=%02h addr=%08h delay=%0d tx_bytes=%0d mem_txn=%0d",
             idx, v.sel, v.cmd, v.addr, v.delay, tx_log.size(), m_addr.size());
  endtask

  vec_t dir[12];

  initial begin
    vec_t        v;
    int          pick, k;
    logic [7:0]  first;
    bit          held;

    dir[0]  = '{1'b0, CR,    32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2,  4, '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b1, 32'h0000_0100, 4'h0, 2};
    dir[1]  = '{1'b0, CW,    32'h0000_0004, 32'h1234_5678, 32'h0,         1,  1, '{8'h4B, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000_0004, 4'hF, 1};
    dir[2]  = '{1'b1, CW,    32'h0000_0004, 32'h1234_5678, 32'h0,         3,  0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000_0004, 4'hF, 3};
    dir[3]  = '{1'b0, 8'h41, 32'h0,         32'h0,         32'h0,         1,  1, '{8'h3F, 8'h00, 8'h00, 8'h00}, 1'b0, 32'h0,         4'h0, 0};
    dir[4]  = '{1'b0, CR,    32'h0000_2003, 32'h0,         32'h0BAD_F00D, 1,  4, '{8'h0D, 8'hF0, 8'hAD, 8'h0B}, 1'b1, 32'h0000_2000, 4'h0, 1};
    dir[5]  = '{1'b0, CR,    32'h0000_0010, 32'h0,         32'h5555_5555, 0,  1, '{8'h54, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000_0010, 4'h0, 8};
    dir[6]  = '{1'b0, CW,    32'h0000_0020, 32'hAABB_CCDD, 32'h0,         8,  1, '{8'h4B, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000_0020, 4'hF, 8};
    dir[7]  = '{1'b0, CR,    32'h0000_0024, 32'h0,         32'h0102_0304, 8,  4, '{8'h04, 8'h03, 8'h02, 8'h01}, 1'b1, 32'h0000_0024, 4'h0, 8};
    dir[8]  = '{1'b0, CW,    32'h0000_0030, 32'h0000_0000, 32'h0,         9,  1, '{8'h54, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000_0030, 4'hF, 8};
    dir[9]  = '{1'b1, CR,    32'h0000_0044, 32'h0,         32'hCAFE_F00D, 40, 4, '{8'h0D, 8'hF0, 8'hFE, 8'hCA}, 1'b1, 32'h0000_0044, 4'h0, 40};
    dir[10] = '{1'b1, 8'h00, 32'h0,         32'h0,         32'h0,         1,  1, '{8'h3F, 8'h00, 8'h00, 8'h00}, 1'b0, 32'h0,         4'h0, 0};
    dir[11] = '{1'b1, CW,    32'h8000_0001, 32'h0000_0001, 32'h0,         7,  0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h8000_0000, 4'hF, 7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst rx_tready", 32'(o_rx_tready), 32'd0);
    check("rst tx_tvalid", 32'(o_tx_tvalid), 32'd0);
    check("rst tx_tdata",  32'(o_tx_tdata),  32'd0);
    check("rst mem_valid", 32'(o_mem_valid), 32'd0);
    check("rst mem_instr", 32'(o_mem_instr), 32'd0);
    check("rst mem_addr",  o_mem_addr,       32'd0);
    check("rst mem_wdata", o_mem_wdata,      32'd0);
    check("rst mem_wstrb", 32'(o_mem_wstrb), 32'd0);
    check("rst busy",      32'(o_busy),      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(dir[i], i);

    // tx back-pressure during a read reply
    clear_logs();
    sel = 1'b0; rsp_delay = 1; rsp_data = 32'h1122_3344;
    tx_tready = 1'b0;
    v = '{1'b0, CR, 32'h0000_0080, 32'h0, 32'h1122_3344, 1, 0, '{default: 8'h00}, 1'b0, 32'h0, 4'h0, 0};
    send_frame(v);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_tx_tvalid) break;
    end
    if (k == 50) fail_bound("stall tx_tvalid");
    first = o_tx_tdata;
    check("stall first_byte", 32'(first), 32'h44);
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (o_tx_tdata !== first || !o_tx_tvalid || o_rx_tready || !o_busy) held = 1'b0;
    end
    check("stall hold", 32'(held), 32'd1);
    @(posedge clk);
    #1;
    tx_tready = 1'b1;
    wait_idle();
    check("stall tx_count", 32'(tx_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++)
      check($sformatf("stall tx_byte%0d", i), 32'(tx_log[i]), 32'(v.rdata[8*i +: 8]));
    check("stall mem_count", 32'(m_addr.size()), 32'd1);
    $display("stall sequence: tx_bytes=%0d", tx_log.size());

    // reset during MEM
    clear_logs();
    rsp_delay = 0;
    v = '{1'b0, CR, 32'h0000_0050, 32'h0, 32'h0, 0, 0, '{default: 8'h00}, 1'b0, 32'h0, 4'h0, 0};
    send_frame(v);
    @(negedge clk);
    check("rstmem mem_valid_before", 32'(o_mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rstmem mem_valid", 32'(o_mem_valid), 32'd0);
    check("rstmem tx_tvalid", 32'(o_tx_tvalid), 32'd0);
    check("rstmem busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    $display("reset during MEM applied");

    // reset during ADDR
    send_byte(CR);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    check("rstaddr busy_before", 32'(o_busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rstaddr busy", 32'(o_busy), 32'd0);
    check("rstaddr rx_tready", 32'(o_rx_tready), 32'd0);
    check("rstaddr mem_valid", 32'(o_mem_valid), 32'd0);
    check("rstaddr tx_tvalid", 32'(o_tx_tvalid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    $display("reset during ADDR applied");

    // reset while a reply is waiting
    tx_tready = 1'b0;
    send_byte(8'h41);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_tx_tvalid) break;
    end
    if (k == 20) fail_bound("rstresp tx_tvalid");
    #2 resetn = 1'b0;
    #1;
    check("rstresp tx_tvalid", 32'(o_tx_tvalid), 32'd0);
    check("rstresp tx_tdata", 32'(o_tx_tdata), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tx_tready = 1'b1;
    @(posedge clk);
    #1;
    $display("reset during RESP applied");

    v = '{1'b0, CR, 32'h0, 32'h0, 32'h89AB_CDEF, 2, 4, '{8'hEF, 8'hCD, 8'hAB, 8'h89}, 1'b1, 32'h0, 4'h0, 2};
    run_vec(v, 50);

    // randomized frames against the reference model, with rx/tx jitter
    stall_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      v.sel = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      if (pick < 4) v.cmd = CW;
      else if (pick < 8) v.cmd = CR;
      else begin
        v.cmd = 8'($urandom);
        while (v.cmd == CW || v.cmd == CR) v.cmd = 8'($urandom);
      end
      v.addr = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.delay = v.sel ? $urandom_range(1, 20) : $urandom_range(0, 10);
      run_vec(model(v), 100 + r);
    end
    stall_en = 1'b0;
    tx_tready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
